// File: rtl/data_mem_ctrl.sv
// Data-memory controller: one 32-bit CPU access = two 16-bit SRAM half-accesses.
// Optional one-entry last-word cache enabled by defining DMEM_LAST_WORD_CACHE_EN.
module data_mem_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned HALF_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_WE_N
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [2:0] CNT_LAST = 3'(HALF_CYCLES - 1);

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic        last;
  logic        req;
  logic        op_wr;
  logic [16:0] word_q;
  logic [16:0] word_in;
  logic [31:0] wdata_q;
  logic        dq_oe;
  logic [15:0] dq_out;
  logic        hit;

  assign req     = MEM_R_EN | MEM_W_EN;
  assign last    = (cnt == CNT_LAST);
  assign word_in = 17'((address - BASE_ADDR) >> 2);
  assign ready   = ~req | (state == DONE);
  assign SRAM_DQ = dq_oe ? dq_out : 'z;

`ifdef DMEM_LAST_WORD_CACHE_EN
  logic        c_valid;
  logic [16:0] c_tag;
  logic [31:0] c_data;

  assign hit = MEM_R_EN & ~MEM_W_EN & c_valid & (c_tag == word_in);

  always_ff @(posedge clk) begin
    if (!rst) begin
      c_valid <= 1'b0;
      c_tag   <= '0;
      c_data  <= '0;
    end else if (state == HIGH && last) begin
      c_valid <= 1'b1;
      c_tag   <= word_q;
      c_data  <= op_wr ? wdata_q : {SRAM_DQ, readData[15:0]};
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = '0;
    case (state)
      IDLE: begin
        if (req) state_nxt = hit ? DONE : LOW;
      end
      LOW: begin
        SRAM_ADDR = {word_q, 1'b0};
        SRAM_WE_N = ~op_wr;
        dq_oe     = op_wr;
        dq_out    = wdata_q[15:0];
        if (last) state_nxt = HIGH;
      end
      HIGH: begin
        SRAM_ADDR = {word_q, 1'b1};
        SRAM_WE_N = ~op_wr;
        dq_oe     = op_wr;
        dq_out    = wdata_q[31:16];
        if (last) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operation, word index and store data are frozen at acceptance so a
  // request dropped mid-transaction still completes unchanged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      readData <= '0;
      op_wr    <= 1'b0;
      word_q   <= '0;
      wdata_q  <= '0;
    end else begin
      if (state == LOW || state == HIGH) cnt <= last ? 3'd0 : cnt + 3'd1;
      else                               cnt <= '0;

      if (state == IDLE && req) begin
        op_wr   <= MEM_W_EN;
        word_q  <= word_in;
        wdata_q <= writeData;
      end

`ifdef DMEM_LAST_WORD_CACHE_EN
      if (state == IDLE && hit) readData <= c_data;
`endif
      if (state == LOW && last && !op_wr)  readData[15:0]  <= SRAM_DQ;
      if (state == HIGH && last && !op_wr) readData[31:16] <= SRAM_DQ;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: vector table of full transactions plus
// hand-written reset-abort and held-request sequences, against a small SRAM model.
module tb_data_mem_ctrl;

  localparam int unsigned HC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] address, writeData;
  logic [31:0] readData;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_WE_N;

  int checks = 0;
  int errors = 0;

  logic [15:0] sram [16] = '{default: 16'h0000};
  logic [15:0] sram_rd;

  always #5 clk = ~clk;

  always_comb sram_rd = sram[SRAM_ADDR[3:0]];
  assign SRAM_DQ = SRAM_WE_N ? sram_rd : 'z;

  always @(posedge clk) if (!SRAM_WE_N) sram[SRAM_ADDR[3:0]] <= SRAM_DQ;

  data_mem_ctrl #(.BASE_ADDR(32'd1024), .HALF_CYCLES(HC)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .address(address), .writeData(writeData), .readData(readData), .ready(ready),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ), .SRAM_WE_N(SRAM_WE_N)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        r, w;
    logic [31:0] addr, wdata, exp_rdata;
    logic [17:0] exp_lo, exp_hi;
    logic [15:0] exp_dq_lo, exp_dq_hi;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int lat;
    bit done;

    vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h00000000, 18'h00000, 18'h00001, 16'hBEEF, 16'hDEAD};
    vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF, 18'h00000, 18'h00001, 16'h0,    16'h0};
    vecs[2] = '{1'b1, 1'b1, 32'd1028, 32'h12345678, 32'hDEADBEEF, 18'h00002, 18'h00003, 16'h5678, 16'h1234};
    vecs[3] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'h12345678, 18'h00002, 18'h00003, 16'h0,    16'h0};
    vecs[4] = '{1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, 32'h12345678, 18'h3FFFE, 18'h3FFFF, 16'hF00D, 16'hCAFE};
    vecs[5] = '{1'b1, 1'b0, 32'd1020, 32'h0,        32'hCAFEF00D, 18'h3FFFE, 18'h3FFFF, 16'h0,    16'h0};
    vecs[6] = '{1'b1, 1'b0, 32'd1027, 32'h0,        32'hDEADBEEF, 18'h00000, 18'h00001, 16'h0,    16'h0};

    rst = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; address = '0; writeData = '0;
    @(negedge clk); @(negedge clk);
    chk("reset_ready", ready, 1);
    chk("reset_rdata", readData, 0);
    chk("reset_we_n", SRAM_WE_N, 1);
    chk("reset_addr", SRAM_ADDR, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      MEM_R_EN = vecs[i].r; MEM_W_EN = vecs[i].w;
      address = vecs[i].addr; writeData = vecs[i].wdata;
      #1 chk($sformatf("v%0d_ready_first", i), ready, 0);
      lat = 0; done = 0;
      for (int k = 1; k <= 30 && !done; k++) begin
        @(negedge clk);
        if (k == 1) begin
          chk($sformatf("v%0d_addr_lo", i), SRAM_ADDR, vecs[i].exp_lo);
          chk($sformatf("v%0d_we_lo", i), SRAM_WE_N, !vecs[i].w);
          if (vecs[i].w) chk($sformatf("v%0d_dq_lo", i), SRAM_DQ, vecs[i].exp_dq_lo);
        end
        if (k == HC + 1) begin
          chk($sformatf("v%0d_addr_hi", i), SRAM_ADDR, vecs[i].exp_hi);
          chk($sformatf("v%0d_we_hi", i), SRAM_WE_N, !vecs[i].w);
          if (vecs[i].w) chk($sformatf("v%0d_dq_hi", i), SRAM_DQ, vecs[i].exp_dq_hi);
        end
        if (ready) begin lat = k; done = 1; end
      end
      chk($sformatf("v%0d_latency", i), lat, 2 * HC + 1);
      chk($sformatf("v%0d_rdata", i), readData, vecs[i].exp_rdata);
      chk($sformatf("v%0d_done_addr", i), SRAM_ADDR, 0);
      chk($sformatf("v%0d_done_we_n", i), SRAM_WE_N, 1);
      MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_idle_ready", i), ready, 1);
    end

    // Reset asserted during the HIGH half of a write.
    MEM_W_EN = 1'b1; address = 32'd1032; writeData = 32'h11112222;
    for (int k = 1; k <= HC + 1; k++) begin
      @(negedge clk);
      if (k == 1) chk("rst_wr_addr_lo", SRAM_ADDR, 18'h00004);
    end
    chk("rst_wr_addr_hi", SRAM_ADDR, 18'h00005);
    chk("rst_wr_we_hi", SRAM_WE_N, 0);
    chk("rst_wr_dq_hi", SRAM_DQ, 16'h1111);
    rst = 1'b0; MEM_W_EN = 1'b0;
    @(negedge clk);
    chk("rst_abort_we_n", SRAM_WE_N, 1);
    chk("rst_abort_addr", SRAM_ADDR, 0);
    chk("rst_abort_rdata", readData, 0);
    chk("rst_abort_ready", ready, 1);
    chk("rst_abort_dq_released", SRAM_DQ, 16'hBEEF);
    rst = 1'b1;
    @(negedge clk);

    // Read request held through DONE: one IDLE cycle with ready=0, then a full repeat.
    MEM_R_EN = 1'b1; address = 32'd1028;
    lat = 0; done = 0;
    for (int k = 1; k <= 30 && !done; k++) begin
      @(negedge clk);
      if (ready) begin lat = k; done = 1; end
    end
    chk("held_lat1", lat, 2 * HC + 1);
    chk("held_rdata1", readData, 32'h12345678);
    @(negedge clk);
    chk("held_idle_ready", ready, 0);
    lat = 0; done = 0;
    for (int k = 1; k <= 30 && !done; k++) begin
      @(negedge clk);
      if (ready) begin lat = k; done = 1; end
    end
    chk("held_lat2", lat, 2 * HC + 1);
    chk("held_rdata2", readData, 32'h12345678);
    MEM_R_EN = 1'b0;
    @(negedge clk);
    chk("held_final_ready", ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
